// File: rtl/gso_pkg.sv
// Shared types and constants for the GSO rotation / angle-extraction blocks.
// Holds the sequencer state encoding, angle scaling constants and a flat-vector slice helper.
package gso_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } gso_state_t;

  // Angles are two's complement with +/-pi at +/-2^(ANGLE_WIDTH-1).
  localparam int GSO_ANGLE_WIDTH = 16;
  localparam int ANGLE_PI        = 2 ** (GSO_ANGLE_WIDTH - 1);
  localparam int ANGLE_HALF_PI   = ANGLE_PI / 2;

  // Widest flat vector the slice helper accepts.
  localparam int FLAT_MAX = 512;

  // Element idx of a flat vector whose elements are width bits wide; caller truncates.
  function automatic logic [31:0] elem_slice(input logic [FLAT_MAX-1:0] flat,
                                             input int idx,
                                             input int width);
    logic [FLAT_MAX-1:0] sh;
    sh = flat >> (idx * width);
    return sh[31:0];
  endfunction

endpackage

// File: rtl/gso_angle_extract.sv
// Extracts N_DIM-1 hyperspherical angles and the norm of one vector using a shared vectoring CORDIC.
// Per-stage latency 2+L (L = CORDIC latency); optional GSO_VEC_WATCHDOG_EN adds a WAIT timeout and sticky err.
module gso_angle_extract
  import gso_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int ANGLE_WIDTH = 16,
  parameter int N_DIM       = 7
`ifdef GSO_VEC_WATCHDOG_EN
  ,
  parameter int WDOG_CYCLES = 64
`endif
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic [DATA_WIDTH*N_DIM-1:0]      w_in_flat,
  input  logic                             cordic_vec_opvld,
  input  logic [DATA_WIDTH-1:0]            cordic_vec_xout,
  input  logic [ANGLE_WIDTH-1:0]           vec_angle_out,
  output logic                             cordic_vec_en,
  output logic [DATA_WIDTH-1:0]            cordic_vec_xin,
  output logic [DATA_WIDTH-1:0]            cordic_vec_yin,
  output logic                             cordic_vec_angle_calc_en,
  output logic [ANGLE_WIDTH*(N_DIM-1)-1:0] thetas_out_flat,
  output logic [DATA_WIDTH-1:0]            norm_out,
  output logic                             busy,
  output logic                             done
`ifdef GSO_VEC_WATCHDOG_EN
  ,
  output logic                             err
`endif
);

  localparam int JW = (N_DIM > 2) ? $clog2(N_DIM - 1) : 1;
  localparam logic [JW-1:0] J_LAST = JW'(N_DIM - 2);

  gso_state_t                    state;
  logic [JW-1:0]                 j;
  logic [DATA_WIDTH*N_DIM-1:0]   w_lat;
  logic [DATA_WIDTH-1:0]         r;
  logic [DATA_WIDTH-1:0]         elem_x;
  logic [DATA_WIDTH-1:0]         elem_y;
  logic [DATA_WIDTH-1:0]         mag_sat;

`ifdef GSO_VEC_WATCHDOG_EN
  localparam int WDW = $clog2(WDOG_CYCLES + 1);
  logic [WDW-1:0] wdog_cnt;
`endif

  assign elem_x = DATA_WIDTH'(elem_slice(FLAT_MAX'(w_lat), 0, DATA_WIDTH));
  assign elem_y = DATA_WIDTH'(elem_slice(FLAT_MAX'(w_lat), int'(j) + 1, DATA_WIDTH));

  // The CORDIC magnitude is unsigned; anything past the signed range clamps to max positive.
  assign mag_sat = cordic_vec_xout[DATA_WIDTH-1] ? {1'b0, {(DATA_WIDTH-1){1'b1}}}
                                                 : cordic_vec_xout;

  always_ff @(posedge clk) begin
    if (rst) begin
      state                    <= IDLE;
      j                        <= '0;
      w_lat                    <= '0;
      r                        <= '0;
      cordic_vec_en            <= 1'b0;
      cordic_vec_angle_calc_en <= 1'b0;
      cordic_vec_xin           <= '0;
      cordic_vec_yin           <= '0;
      thetas_out_flat          <= '0;
      norm_out                 <= '0;
      busy                     <= 1'b0;
      done                     <= 1'b0;
`ifdef GSO_VEC_WATCHDOG_EN
      wdog_cnt                 <= '0;
      err                      <= 1'b0;
`endif
    end else begin
      cordic_vec_en            <= 1'b0;
      cordic_vec_angle_calc_en <= 1'b0;
      done                     <= 1'b0;
      case (state)
        IDLE: begin
          if (en) begin
            w_lat <= w_in_flat;
            j     <= '0;
            busy  <= 1'b1;
            state <= ISSUE;
`ifdef GSO_VEC_WATCHDOG_EN
            err   <= 1'b0;
`endif
          end
        end
        ISSUE: begin
          cordic_vec_en            <= 1'b1;
          cordic_vec_angle_calc_en <= 1'b1;
          cordic_vec_xin           <= (j == '0) ? elem_x : r;
          cordic_vec_yin           <= elem_y;
          state                    <= WAIT;
`ifdef GSO_VEC_WATCHDOG_EN
          wdog_cnt                 <= '0;
`endif
        end
        WAIT: begin
          if (cordic_vec_opvld) begin
            thetas_out_flat[int'(j)*ANGLE_WIDTH +: ANGLE_WIDTH] <= vec_angle_out;
            r <= mag_sat;
            if (j == J_LAST) begin
              state <= DONE;
            end else begin
              j     <= j + 1'b1;
              state <= ISSUE;
            end
          end
`ifdef GSO_VEC_WATCHDOG_EN
          // Timeout abandons the vector: thetas not yet written keep their old values.
          else if (wdog_cnt == WDW'(WDOG_CYCLES)) begin
            err   <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            wdog_cnt <= wdog_cnt + 1'b1;
          end
`endif
        end
        DONE: begin
          norm_out <= r;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gso_angle_extract.sv
// Bench for gso_angle_extract: plays the CORDIC with a real-arithmetic responder and
// compares against a vector-level reference of the angle/norm extraction.
`timescale 1ns/1ps
module tb_gso_angle_extract;
  import gso_pkg::*;

  localparam int DW = 16;
  localparam int AW = 16;
  localparam int N  = 7;
  localparam int NA = N - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic [DW*N-1:0]   w_in_flat;
  logic              cordic_vec_opvld;
  logic [DW-1:0]     cordic_vec_xout;
  logic [AW-1:0]     vec_angle_out;
  logic              cordic_vec_en;
  logic [DW-1:0]     cordic_vec_xin;
  logic [DW-1:0]     cordic_vec_yin;
  logic              cordic_vec_angle_calc_en;
  logic [AW*NA-1:0]  thetas_out_flat;
  logic [DW-1:0]     norm_out;
  logic              busy;
  logic              done;
`ifdef GSO_VEC_WATCHDOG_EN
  logic              err;
`endif

  int checks = 0;
  int errors = 0;
  int lat = 2;
  bit mute = 0;
  int en_pulses = 0;
  int b2b = 0;
  int done_pulses = 0;
  int last_th[NA];
  int last_norm = 0;

  always #5 clk = ~clk;

  gso_angle_extract #(.DATA_WIDTH(DW), .ANGLE_WIDTH(AW), .N_DIM(N)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .en                       (en),
    .w_in_flat                (w_in_flat),
    .cordic_vec_opvld         (cordic_vec_opvld),
    .cordic_vec_xout          (cordic_vec_xout),
    .vec_angle_out            (vec_angle_out),
    .cordic_vec_en            (cordic_vec_en),
    .cordic_vec_xin           (cordic_vec_xin),
    .cordic_vec_yin           (cordic_vec_yin),
    .cordic_vec_angle_calc_en (cordic_vec_angle_calc_en),
    .thetas_out_flat          (thetas_out_flat),
    .norm_out                 (norm_out),
    .busy                     (busy),
    .done                     (done)
`ifdef GSO_VEC_WATCHDOG_EN
    ,
    .err                      (err)
`endif
  );

  function automatic int mag_q(input int x, input int y);
    real m;
    m = $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
    return int'(m);
  endfunction

  function automatic int ang_q(input int y, input int x);
    real a;
    a = $atan2(real'(y), real'(x)) * real'(ANGLE_PI) / 3.14159265358979;
    return int'(a);
  endfunction

  // Vector-level reference: chain of (r, w[j+1]) polar conversions with the norm clamped to 15 bits.
  function automatic void ref_model(input int w[N], output int th[NA], output int nrm);
    int r;
    r = w[0];
    for (int k = 0; k < NA; k++) begin
      th[k] = ang_q(w[k+1], r);
      r = mag_q(r, w[k+1]);
      if (r > 32767) r = 32767;
    end
    nrm = r;
  endfunction

  function automatic int adiff(input logic [AW-1:0] a, input int b);
    logic [AW-1:0] d;
    int s;
    d = a - AW'(b);
    s = int'($signed(d));
    return (s < 0) ? -s : s;
  endfunction

  function automatic logic [DW*N-1:0] pack(input int w[N]);
    logic [DW*N-1:0] p;
    for (int k = 0; k < N; k++) p[k*DW +: DW] = DW'(w[k]);
    return p;
  endfunction

  // CORDIC stand-in: result valid lat cycles after the request is seen.
  initial begin
    int cnt;
    bit pending;
    bit prev_en;
    int px;
    int py;
    cnt = 0; pending = 0; prev_en = 0; px = 0; py = 0;
    cordic_vec_opvld = 1'b0;
    cordic_vec_xout  = '0;
    vec_angle_out    = '0;
    forever begin
      @(negedge clk);
      cordic_vec_opvld = 1'b0;
      if (pending) begin
        cnt--;
        if (cnt <= 0) begin
          pending = 0;
          if (!mute) begin
            cordic_vec_opvld = 1'b1;
            cordic_vec_xout  = DW'(mag_q(px, py));
            vec_angle_out    = AW'(ang_q(py, px));
          end
        end
      end
      if (cordic_vec_en === 1'b1) begin
        pending = 1;
        cnt = lat;
        px = int'($signed(cordic_vec_xin));
        py = int'($signed(cordic_vec_yin));
        en_pulses++;
        if (prev_en) b2b++;
      end
      prev_en = (cordic_vec_en === 1'b1);
      if (done === 1'b1) done_pulses++;
    end
  end

  task automatic run_vec(input int w[N], input int poke_a, input int poke_b,
                         output int cyc, output bit timed_out, output logic busy0);
    @(negedge clk);
    w_in_flat = pack(w);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    busy0 = busy;
    cyc = 0;
    timed_out = 1;
    for (int k = 0; k < 3000; k++) begin
      en = (cyc == poke_a || cyc == poke_b) ? 1'b1 : 1'b0;
      if (en) w_in_flat = ~w_in_flat;
      @(negedge clk);
      cyc++;
      if (done === 1'b1) begin
        timed_out = 0;
        break;
      end
    end
    en = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b0; w_in_flat = '0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (cordic_vec_en !== 1'b0 || cordic_vec_angle_calc_en !== 1'b0) begin
      errors++; $display("FAIL reset_req: got %b/%b want 0/0", cordic_vec_en, cordic_vec_angle_calc_en); end
    checks++; if (thetas_out_flat !== '0 || norm_out !== '0) begin
      errors++; $display("FAIL reset_results: thetas %h norm %h want 0", thetas_out_flat, norm_out); end
    checks++; if (cordic_vec_xin !== '0 || cordic_vec_yin !== '0) begin
      errors++; $display("FAIL reset_xy: got %h/%h want 0", cordic_vec_xin, cordic_vec_yin); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int w[N]; int cyc; bit to; logic b0; int e0; int d0; int b2b0;
    w = '{100, 0, 0, 0, 0, 0, 0};
    lat = $urandom_range(1, 5);
    e0 = en_pulses; d0 = done_pulses; b2b0 = b2b;
    run_vec(w, -1, -1, cyc, to, b0);
    checks++; if (to) begin errors++; $display("FAIL basic_timeout: no done within 3000 cycles"); end
    checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", b0); end
    checks++; if (cyc != NA*(2+lat)+1) begin errors++; $display("FAIL basic_latency: got %0d want %0d", cyc, NA*(2+lat)+1); end
    for (int k = 0; k < NA; k++) begin
      checks++; if (adiff(thetas_out_flat[k*AW +: AW], 0) > 2) begin
        errors++; $display("FAIL basic_theta%0d: got %h want 0000", k, thetas_out_flat[k*AW +: AW]); end
    end
    checks++; if (int'(norm_out) < 98 || int'(norm_out) > 102) begin
      errors++; $display("FAIL basic_norm: got %0d want 100", norm_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end: got %b want 0", busy); end
    repeat (8) @(negedge clk);
    checks++; if (done_pulses - d0 != 1) begin errors++; $display("FAIL basic_done_pulses: got %0d want 1", done_pulses - d0); end
    checks++; if (en_pulses - e0 != NA) begin errors++; $display("FAIL basic_req_count: got %0d want %0d", en_pulses - e0, NA); end
    checks++; if (b2b != b2b0) begin errors++; $display("FAIL basic_req_b2b: got %0d want 0", b2b - b2b0); end
  endtask

  task automatic test_axes;
    int w[N]; int cyc; bit to; logic b0;
    lat = 3;
    w = '{0, 100, 0, 0, 0, 0, 0};
    run_vec(w, -1, -1, cyc, to, b0);
    checks++; if (to || adiff(thetas_out_flat[0 +: AW], ANGLE_HALF_PI) > 2) begin
      errors++; $display("FAIL axis_y_theta0: got %h want 4000 (timeout %0b)", thetas_out_flat[0 +: AW], to); end
    for (int k = 1; k < NA; k++) begin
      checks++; if (adiff(thetas_out_flat[k*AW +: AW], 0) > 2) begin
        errors++; $display("FAIL axis_y_theta%0d: got %h want 0000", k, thetas_out_flat[k*AW +: AW]); end
    end
    checks++; if (int'(norm_out) < 98 || int'(norm_out) > 102) begin
      errors++; $display("FAIL axis_y_norm: got %0d want 100", norm_out); end
    w = '{-100, 0, 0, 0, 0, 0, 0};
    run_vec(w, -1, -1, cyc, to, b0);
    checks++; if (to || adiff(thetas_out_flat[0 +: AW], ANGLE_PI) > 2) begin
      errors++; $display("FAIL axis_negx_theta0: got %h want 8000 (timeout %0b)", thetas_out_flat[0 +: AW], to); end
    checks++; if (int'(norm_out) < 98 || int'(norm_out) > 102) begin
      errors++; $display("FAIL axis_negx_norm: got %0d want 100", norm_out); end
  endtask

  task automatic test_all100;
    int w[N]; int th[NA]; int nrm; int cyc; bit to; logic b0; int e0; int b2b0;
    w = '{100, 100, 100, 100, 100, 100, 100};
    lat = 4;
    ref_model(w, th, nrm);
    e0 = en_pulses; b2b0 = b2b;
    run_vec(w, -1, -1, cyc, to, b0);
    checks++; if (to || adiff(thetas_out_flat[0 +: AW], ANGLE_PI / 4) > 2) begin
      errors++; $display("FAIL all100_theta0: got %h want 2000 (timeout %0b)", thetas_out_flat[0 +: AW], to); end
    for (int k = 1; k < NA; k++) begin
      checks++; if (adiff(thetas_out_flat[k*AW +: AW], th[k]) > 1) begin
        errors++; $display("FAIL all100_theta%0d: got %h want %h", k, thetas_out_flat[k*AW +: AW], AW'(th[k])); end
    end
    checks++; if (int'(norm_out) < 262 || int'(norm_out) > 268) begin
      errors++; $display("FAIL all100_norm: got %0d want 265", norm_out); end
    repeat (2) @(negedge clk);
    checks++; if (en_pulses - e0 != NA || b2b != b2b0) begin
      errors++; $display("FAIL all100_reqs: got %0d requests %0d adjacent want %0d/0", en_pulses - e0, b2b - b2b0, NA); end
  endtask

  task automatic test_random;
    int w[N]; int th[NA]; int nrm; int cyc; bit to; logic b0;
    for (int t = 0; t < 8; t++) begin
      lat = $urandom_range(1, 6);
      w[0] = $urandom_range(500, 4000);
      if ($urandom_range(0, 1) == 1) w[0] = -w[0];
      for (int k = 1; k < N; k++) w[k] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 8000)) - 4000;
      ref_model(w, th, nrm);
      run_vec(w, -1, -1, cyc, to, b0);
      checks++; if (to || cyc != NA*(2+lat)+1) begin
        errors++; $display("FAIL rand%0d_latency: got %0d want %0d (timeout %0b)", t, cyc, NA*(2+lat)+1, to); end
      for (int k = 0; k < NA; k++) begin
        checks++; if (adiff(thetas_out_flat[k*AW +: AW], th[k]) > 1) begin
          errors++; $display("FAIL rand%0d_theta%0d: got %h want %h", t, k, thetas_out_flat[k*AW +: AW], AW'(th[k])); end
      end
      checks++; if (int'(norm_out) < nrm - 1 || int'(norm_out) > nrm + 1) begin
        errors++; $display("FAIL rand%0d_norm: got %0d want %0d", t, norm_out, nrm); end
      last_th = th; last_norm = nrm;
    end
  endtask

  task automatic test_saturation;
    int w[N]; int cyc; bit to; logic b0;
    w = '{30000, 30000, 0, 0, 0, 0, 0};
    lat = 2;
    run_vec(w, -1, -1, cyc, to, b0);
    checks++; if (to || norm_out !== 16'h7FFF) begin
      errors++; $display("FAIL sat_norm: got %h want 7fff (timeout %0b)", norm_out, to); end
    checks++; if (adiff(thetas_out_flat[0 +: AW], ANGLE_PI / 4) > 2) begin
      errors++; $display("FAIL sat_theta0: got %h want 2000", thetas_out_flat[0 +: AW]); end
  endtask

  task automatic test_zero;
    int w[N]; int cyc; bit to; logic b0; int e0;
    w = '{0, 0, 0, 0, 0, 0, 0};
    lat = 1;
    e0 = en_pulses;
    run_vec(w, -1, -1, cyc, to, b0);
    checks++; if (to || norm_out !== '0) begin
      errors++; $display("FAIL zero_norm: got %0d want 0 (timeout %0b)", norm_out, to); end
    checks++; if (en_pulses - e0 != NA) begin
      errors++; $display("FAIL zero_reqs: got %0d want %0d", en_pulses - e0, NA); end
  endtask

  task automatic test_busy_en;
    int w[N]; int th[NA]; int nrm; int cyc; bit to; logic b0; int e0; int d0; int tot;
    lat = 3;
    tot = NA*(2+lat)+1;
    for (int k = 0; k < N; k++) w[k] = int'($urandom_range(0, 4000)) - 2000;
    w[0] = 3000;
    ref_model(w, th, nrm);
    e0 = en_pulses; d0 = done_pulses;
    run_vec(w, 3, tot - 1, cyc, to, b0);
    checks++; if (to || cyc != tot) begin
      errors++; $display("FAIL busy_en_latency: got %0d want %0d (timeout %0b)", cyc, tot, to); end
    for (int k = 0; k < NA; k++) begin
      checks++; if (adiff(thetas_out_flat[k*AW +: AW], th[k]) > 1) begin
        errors++; $display("FAIL busy_en_theta%0d: got %h want %h", k, thetas_out_flat[k*AW +: AW], AW'(th[k])); end
    end
    repeat (12) @(negedge clk);
    checks++; if (en_pulses - e0 != NA || done_pulses - d0 != 1 || busy !== 1'b0) begin
      errors++; $display("FAIL busy_en_ignored: reqs %0d dones %0d busy %b want %0d/1/0", en_pulses - e0, done_pulses - d0, busy, NA); end
    checks++; if (int'(norm_out) < nrm - 1 || int'(norm_out) > nrm + 1) begin
      errors++; $display("FAIL busy_en_hold_norm: got %0d want %0d", norm_out, nrm); end
    last_th = th; last_norm = nrm;
  endtask

  task automatic test_reset_mid;
    int w[N]; int th[NA]; int nrm; int cyc; bit to; logic b0; int e0; int e1; int d0;
    lat = 6;
    for (int k = 0; k < N; k++) w[k] = int'($urandom_range(0, 2000)) - 1000;
    w[0] = 3000;
    e0 = en_pulses;
    @(negedge clk); w_in_flat = pack(w); en = 1'b1;
    @(negedge clk); en = 1'b0;
    for (int k = 0; k < 500 && (en_pulses - e0) < 3; k++) @(negedge clk);
    checks++; if (en_pulses - e0 != 3) begin
      errors++; $display("FAIL rstmid_reach_stage3: got %0d requests want 3", en_pulses - e0); end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || thetas_out_flat !== '0 || norm_out !== '0) begin
      errors++; $display("FAIL rstmid_clear: busy %b done %b thetas %h norm %h want all 0", busy, done, thetas_out_flat, norm_out); end
    e1 = en_pulses; d0 = done_pulses;
    repeat (12) @(negedge clk);
    checks++; if (done_pulses != d0 || en_pulses != e1 || busy !== 1'b0 || thetas_out_flat !== '0) begin
      errors++; $display("FAIL rstmid_stray: dones %0d reqs %0d busy %b thetas %h want 0/0/0/0", done_pulses - d0, en_pulses - e1, busy, thetas_out_flat); end
    ref_model(w, th, nrm);
    run_vec(w, -1, -1, cyc, to, b0);
    checks++; if (to || int'(norm_out) < nrm - 1 || int'(norm_out) > nrm + 1) begin
      errors++; $display("FAIL rstmid_rerun_norm: got %0d want %0d (timeout %0b)", norm_out, nrm, to); end
    checks++; if (adiff(thetas_out_flat[(NA-1)*AW +: AW], th[NA-1]) > 1) begin
      errors++; $display("FAIL rstmid_rerun_theta: got %h want %h", thetas_out_flat[(NA-1)*AW +: AW], AW'(th[NA-1])); end
    last_th = th; last_norm = nrm;
  endtask

`ifdef GSO_VEC_WATCHDOG_EN
  task automatic test_watchdog;
    int w[N]; int cyc; bit to; logic b0;
    lat = 2;
    for (int k = 0; k < N; k++) w[k] = int'($urandom_range(0, 2000)) - 1000;
    w[0] = 2500;
    mute = 1;
    run_vec(w, -1, -1, cyc, to, b0);
    checks++; if (to || cyc != 1 + 1 + 64) begin
      errors++; $display("FAIL wdog_latency: got %0d want 66 (timeout %0b)", cyc, to); end
    checks++; if (err !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL wdog_err: err %b busy %b want 1/0", err, busy); end
    for (int k = 0; k < NA; k++) begin
      checks++; if (adiff(thetas_out_flat[k*AW +: AW], last_th[k]) > 1) begin
        errors++; $display("FAIL wdog_hold_theta%0d: got %h want %h", k, thetas_out_flat[k*AW +: AW], AW'(last_th[k])); end
    end
    repeat (4) @(negedge clk);
    mute = 0;
    run_vec(w, -1, -1, cyc, to, b0);
    checks++; if (to || err !== 1'b0) begin
      errors++; $display("FAIL wdog_err_clear: got %b want 0 (timeout %0b)", err, to); end
  endtask
`endif

  initial begin
    rst = 1'b1; en = 1'b0; w_in_flat = '0;
    test_reset();
    test_basic();
    test_axes();
    test_all100();
    test_random();
    test_saturation();
    test_zero();
    test_busy_en();
    test_reset_mid();
`ifdef GSO_VEC_WATCHDOG_EN
    test_watchdog();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gso_angle_extract.md
Name: gso_angle_extract

Overview:
- Inverse of the GSO rotation controller: takes one N_DIM-element vector and, using the shared doubly-pipelined CORDIC in vectoring mode, extracts the N_DIM-1 hyperspherical angles and the vector norm.
- The angle set it produces is the one the rotation controller consumes via thetas_in_flat.
- Sits between the FastICA weight update and the GSO stage, driving the cordic_vec_* side of CORDIC_doubly_pipe_top.

Parameters:
- DATA_WIDTH, 16, signed width of vector elements, CORDIC x/y and norm.
- ANGLE_WIDTH, 16, signed angle width; ±π maps to ±2^(ANGLE_WIDTH-1).
- N_DIM, 7, vector length; produces N_DIM-1 angles.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- en  in  1  start pulse; sampled only in IDLE.
- w_in_flat  in  DATA_WIDTH*N_DIM  signed input vector; element i at [(i+1)*DATA_WIDTH-1 -: DATA_WIDTH].
- cordic_vec_opvld  in  1  CORDIC vectoring result valid.
- cordic_vec_xout  in  DATA_WIDTH  gain-compensated magnitude from CORDIC.
- vec_angle_out  in  ANGLE_WIDTH  angle from CORDIC.
- cordic_vec_en  out  1  one-cycle vectoring request.
- cordic_vec_xin  out  DATA_WIDTH  registered x operand.
- cordic_vec_yin  out  DATA_WIDTH  registered y operand.
- cordic_vec_angle_calc_en  out  1  high with cordic_vec_en; requests angle output.
- thetas_out_flat  out  ANGLE_WIDTH*(N_DIM-1)  angle j at [(j+1)*ANGLE_WIDTH-1 -: ANGLE_WIDTH].
- norm_out  out  DATA_WIDTH  final magnitude.
- busy  out  1  high from accepted en until done.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: all outputs 0, state IDLE, stage counter 0, latched vector cleared.
- Algorithm: r = w[0]; for j = 0..N_DIM-2, vector (x=r, y=w[j+1]), giving theta[j] = vec_angle_out and r = cordic_vec_xout. norm_out = final r.
- IDLE: en=1 latches w_in_flat, sets j=0, sets busy, moves to ISSUE. en=0 stays in IDLE.
- ISSUE: drive cordic_vec_en=1 and cordic_vec_angle_calc_en=1 for exactly one cycle, with xin/yin registered (x = w[0] when j=0, else r). Moves to WAIT.
- WAIT: hold until cordic_vec_opvld=1. That cycle, capture theta[j] and r. Magnitude is treated as unsigned and saturated to 2^(DATA_WIDTH-1)-1 if the MSB is set.
  - j < N_DIM-2: increment j, go to ISSUE.
  - j = N_DIM-2: go to DONE.
- DONE: norm_out <= r, done=1 for one cycle, busy=0, return to IDLE.
- thetas_out_flat and norm_out hold their values until the next accepted en. Each theta is written when its stage completes.
- Latency per stage is 2+L cycles, where L is the cycle count from cordic_vec_en to opvld. Total from en sample to done is (N_DIM-1)*(2+L)+1 cycles.
- Boundary conditions:
  - en while busy, including the DONE cycle: ignored.
  - opvld outside WAIT: ignored (covers late results after reset).
  - rst mid-operation: next cycle is IDLE with all outputs 0; an in-flight CORDIC result is dropped.
  - x=y=0: the pair is issued anyway; the theta is whatever the CORDIC returns.
  - Negative x at j=0: the CORDIC quadrant logic resolves it, so theta0 may be ±π.

Optional Feature:
- GSO_VEC_WATCHDOG_EN: adds parameter WDOG_CYCLES (default 64) and output err (1 bit, reset 0).
  - A counter runs in WAIT. If it reaches WDOG_CYCLES without opvld: set err=1 (sticky until rst or next accepted en), pulse done, clear busy, return to IDLE, and leave the remaining thetas at their previous values.
- Without the macro: no counter, no err port, WAIT holds indefinitely.

Decomposition:
- Shared package gso_pkg:
  - state enum (IDLE, ISSUE, WAIT, DONE);
  - ANGLE_PI = 2^(ANGLE_WIDTH-1) and ANGLE_HALF_PI constants;
  - element slice helper for flat vectors.
- Single module, no sub-modules. The magnitude saturation is inline logic.

Test Plan:
- w=(100,0,0,0,0,0,0), en pulse -> all thetas 0x0000 (±2 LSB), norm_out 100 (±2), done after (6*(2+L)+1) cycles, single done pulse.
- w=(0,100,0,0,0,0,0) -> theta0 0x4000, theta1..5 0x0000, norm_out 100; w=(-100,0,...) -> theta0 0x8000 (or 0x7FFF), norm 100.
- w all 100 -> theta0 0x2000, theta1 0x1913 (35.26°), norm_out 265 (±3); cordic_vec_en high exactly 6 cycles total, never two in a row.
- Assert rst during stage 3 wait, then return opvld -> outputs and busy 0, no done, stray opvld ignored; a fresh en then completes normally.
- en re-pulsed while busy and in the DONE cycle -> ignored; the result matches a single run; outputs hold after done.
- With GSO_VEC_WATCHDOG_EN and WDOG_CYCLES=64, CORDIC opvld tied 0 -> err=1 and done pulse at cycle 1+1+64 after en; the next en clears err.
